// File: rtl/mod_split_if.sv
// mod_split_if: stream bundle for mod_split.
// Input side carries a packed word of three FW-bit fields {a,b,c}.
// Output side carries one field per beat with its index and a last flag.
// The slave modport is the splitter; the master modport is its environment.
interface mod_split_if #(
    parameter int FW = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [3*FW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [FW-1:0]   out_data;
    logic [1:0]      out_idx;
    logic            out_last;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_idx,
        output out_last
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_idx,
        input  out_last
    );
endinterface

// File: rtl/mod_split.sv
// mod_split: accepts a packed word {a,b,c} and emits its three fields one
// per beat (a first) with a field index and a last flag.
// Optional feature: define MOD_SPLIT_PIPE_EN to let a new word be accepted on
// the same edge the last field leaves, removing the idle beat between words.
module mod_split #(
    parameter int FW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    mod_split_if.slave  bus
);
    localparam int WW = 3 * FW;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [WW-1:0]   word_r;
    logic [WW-1:0]   word_s;
    logic [1:0]      idx_r;
    logic [1:0]      idx_s;
    logic            run_r;
    logic            in_ready_s;
    logic            in_fire_s;
    logic            out_fire_s;
    logic [FW-1:0]   field_s;

    // Handshake qualification; in_ready stays low until the first edge after reset.
    always_comb begin
        in_ready_s = 1'b0;
        if (!run_r) begin
            in_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else begin
`ifdef MOD_SPLIT_PIPE_EN
            in_ready_s = (idx_r == 2'd2) && bus.out_ready;
`else
            in_ready_s = 1'b0;
`endif
        end
    end

    assign in_fire_s  = bus.in_valid && in_ready_s;
    assign out_fire_s = (state_r == EMIT) && bus.out_ready;

    // Next-state, next-index and word-capture decisions.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        word_s  = word_r;
        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    word_s  = bus.in_data;
                    idx_s   = 2'd0;
                    state_s = EMIT;
                end else begin
                    idx_s   = 2'd0;
                end
            end
            EMIT: begin
                if (!out_fire_s) begin
                    idx_s = idx_r;
                end else if (idx_r != 2'd2) begin
                    idx_s = idx_r + 2'd1;
                end else if (in_fire_s) begin
                    // Back-to-back load: only reachable with the pipe feature.
                    word_s  = bus.in_data;
                    idx_s   = 2'd0;
                    state_s = EMIT;
                end else begin
                    idx_s   = 2'd0;
                    state_s = IDLE;
                end
            end
            default: begin
                idx_s   = 2'd0;
                state_s = IDLE;
            end
        endcase
    end

    // State, index and captured word; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
            word_r  <= {WW{1'b0}};
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            word_r  <= word_s;
            run_r   <= 1'b1;
        end
    end

    // Select the current field from the captured word by index.
    always_comb begin
        field_s = {FW{1'b0}};
        case (idx_r)
            2'd0:    field_s = word_r[WW-1 -: FW];
            2'd1:    field_s = word_r[2*FW-1 -: FW];
            2'd2:    field_s = word_r[FW-1:0];
            default: field_s = {FW{1'b0}};
        endcase
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == EMIT);
    assign bus.out_data  = field_s;
    assign bus.out_idx   = idx_r;
    assign bus.out_last  = (state_r == EMIT) && (idx_r == 2'd2);
endmodule
